pri_encoder_queue: RTL
======================

Name: pri_encoder_queue

Overview:
- Sequential 4-to-2 encoder: the encoding counterpart of the team's 2-to-4 one-hot decoder.
- Captures one-hot/multi-hot request pulses into a sticky pending register.
- Emits the binary index of the highest-priority pending request over a valid/ready output handshake, clearing each index once consumed.
- Sits between event sources (interrupt/strobe lines) and a consumer that decodes indices back to one-hot.

Parameters:
- N, 4, number of request lines (N ≥ 2).
- W, 2, index width; W = clog2(N).
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request pulses; bit k high for a cycle = one event on line k.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_valid  output  1  out_idx holds a valid encoded request.
- out_idx  output  W  binary index of the served request line.
- pending  output  N  sticky pending bits, excluding the one currently presented.
- busy  output  1  out_valid OR (pending != 0).
- drop_cnt  output  CNT_W  count of cycles in which a request hit an already-pending bit; saturates at all-ones.

Behaviour:
- Reset: when rst is sampled high, at that edge pending=0, out_valid=0, out_idx=0, drop_cnt=0, FSM=IDLE. Reset mid-operation discards all pending events and the presented index.
- Priority: fixed; the lowest set index wins (bit 0 highest priority).
- Pending update, each edge: pending_next = (pending & ~clr_mask) | req.
  - clr_mask is the one-hot of the index loaded into the output register that edge, or 0 if none is loaded.
- Drop rule: if (req & pending & ~clr_mask) != 0, drop_cnt increments by 1 for that cycle, regardless of how many bits collided, and saturates at 2^CNT_W-1.
  - A req on a bit being loaded into the output that same edge is a new event: it re-sets pending and is not a drop.
  - A req on the bit currently presented but not pending sets pending and is not a drop.
- FSM states IDLE and HOLD:
  - IDLE: out_valid=0. If pending != 0, at the edge load out_idx = lowest set index, clear that bit, go to HOLD.
  - HOLD: out_valid=1; out_idx is stable while out_ready=0.
  - On transfer (out_valid & out_ready) with pending (pre-update) != 0: load the next lowest index in the same edge and stay in HOLD, giving back-to-back transfers with no bubble.
  - On transfer with pending == 0: go to IDLE and drop out_valid.
- Latency: req sampled high at edge k gives pending bit set after k. If the output is free, out_valid=1 with that index after edge k+1, i.e. 2 cycles request-to-valid.
- Selection uses the registered pending only; req arriving in the same cycle is never bypassed to the output.
- No ordering across lines: a pending low index always overtakes an older pending higher index.
- out_ready while out_valid=0 is ignored.
- The binary index maps exactly to the decoder's one-hot input (index k ↔ one-hot bit k).

Test Plan:
1. Reset then single pulse req=4'b0100 for 1 cycle, out_ready=1 → out_valid=1 with out_idx=2 two edges after the pulse, held for exactly 1 cycle; pending=0; busy=0 afterwards; drop_cnt=0.
2. req=4'b1011 for one cycle, out_ready=1 → consecutive outputs out_idx=0,1,3 on three back-to-back cycles, then out_valid=0.
3. Backpressure: req=4'b0010, out_ready=0 for 5 cycles → out_valid=1 and out_idx=1 stable throughout. Then req=4'b0001 → pending=4'b0001; when out_ready=1 the next index is 0.
4. Drops: with out_ready=0 and pending bit 3 set, pulse req=4'b1000 three times plus once req=4'b1100 → drop_cnt=4; pending=4'b1100. Force 300 collisions → drop_cnt saturates at 255.
5. Same-edge re-request: presenting idx 2 with pending=4'b0100, then at the transfer edge req=4'b0100 → pending still 4'b0100; no drop; idx 2 is presented again next.
6. Reset mid-operation: pending=4'b1110 with out_valid=1, assert rst for 1 cycle → next cycle out_valid=0, pending=0, drop_cnt=0, busy=0; a subsequent req=4'b0001 is served normally with 2-cycle latency.

Source files
------------

// File: rtl/pri_encoder_queue_if.sv
// Request/handshake bundle for pri_encoder_queue: event lines in,
// encoded index out over valid/ready, plus status.
interface pri_encoder_queue_if #(
    parameter int N     = 4,
    parameter int W     = 2,
    parameter int CNT_W = 8
);
    logic [N-1:0]     req;
    logic             out_ready;
    logic             out_valid;
    logic [W-1:0]     out_idx;
    logic [N-1:0]     pending;
    logic             busy;
    logic [CNT_W-1:0] drop_cnt;

    // Event sources / consumer side
    modport master (
        output req, out_ready,
        input  out_valid, out_idx, pending, busy, drop_cnt
    );

    // Encoder side
    modport slave (
        input  req, out_ready,
        output out_valid, out_idx, pending, busy, drop_cnt
    );
endinterface

// File: rtl/pri_encoder_queue.sv
// Sticky 4-to-2 priority encoder: collects request pulses and hands out the
// lowest pending index over valid/ready, counting collisions on pending bits.
module pri_encoder_queue #(
    parameter int N     = 4,
    parameter int W     = 2,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    pri_encoder_queue_if.slave     bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [W-1:0]     sel;
    logic             has_pend;
    logic             load;
    logic [N-1:0]     clr_mask;
    logic             drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        sel      = '0;
        has_pend = |pending_q;
        state_d  = state_q;
        load     = 1'b0;

        // Scan downward so the lowest set index is the one left in sel
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) sel = W'(i);
        end

        case (state_q)
            IDLE: begin
                if (has_pend) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    load    = has_pend;
                    state_d = has_pend ? HOLD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        clr_mask  = load ? (N'(1) << sel) : '0;
        pending_d = (pending_q & ~clr_mask) | bus.req;
        idx_d     = load ? sel : idx_q;

        // A re-request of the bit being loaded this edge is a fresh event, not a drop
        drop   = |(bus.req & pending_q & ~clr_mask);
        drop_d = (drop && drop_q != {CNT_W{1'b1}}) ? drop_q + 1'b1 : drop_q;
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_idx   = idx_q;
    assign bus.pending   = pending_q;
    assign bus.busy      = bus.out_valid | has_pend;
    assign bus.drop_cnt  = drop_q;
endmodule
